if_fetch_unit: RTL and testbench

//   Instruction-fetch stage: owns the PC and drives the IF->ID pipeline register
//   (pc_out/instruction feed its pc_in/instruction_in).

---
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 tb/tb_if_fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to a variable-latency
// instruction memory and presents fetched words (or bubbles) to the IF->ID register.
module if_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              freeze_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic [31:0]       instruction_o,
  output logic              fetch_stall_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  // FETCH: request outstanding at pc; HOLD: frozen with a captured word;
  // DRAIN: redirect pending but the old request must complete first.
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] redir_addr_q, redir_addr_d;

  logic              req, valid, stall;
  logic [31:0]       word;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      redir_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      redir_addr_q <= redir_addr_d;
    end
  end

  // Next state and next PC; branch beats freeze beats sequential advance
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    redir_addr_d = redir_addr_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready_i) begin
          if (branch_taken_i) begin
            // word still presented this cycle; ID flush squashes it
            pc_d = branch_addr_i;
          end else if (freeze_i) begin
            hold_instr_d = imem_rdata_i;
            state_d      = S_HOLD;
          end else begin
            pc_d = pc_q + STEP;
          end
        end else if (branch_taken_i) begin
          // the in-flight request cannot be aborted; remember where to go
          redir_addr_d = branch_addr_i;
          state_d      = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (branch_taken_i) begin
          pc_d    = branch_addr_i;
          state_d = S_FETCH;
        end else if (!freeze_i) begin
          pc_d    = pc_q + STEP;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_ready_i) begin
          pc_d    = branch_taken_i ? branch_addr_i : redir_addr_q;
          state_d = S_FETCH;
        end else if (branch_taken_i) begin
          redir_addr_d = branch_addr_i;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Per-state request, presented word, validity and stall indication
  always_comb begin
    req   = 1'b0;
    valid = 1'b0;
    stall = 1'b0;
    word  = '0;
    case (state_q)
      S_FETCH: begin
        req   = 1'b1;
        word  = imem_rdata_i;
        valid = imem_ready_i;
        stall = !imem_ready_i;
      end
      S_HOLD: begin
        word  = hold_instr_q;
        valid = 1'b1;
      end
      S_DRAIN: begin
        req   = 1'b1;
        stall = 1'b1;
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted
  always_comb begin
    imem_req_o    = req & rst_ni;
    imem_addr_o   = pc_q;
    fetch_stall_o = stall & rst_ni;
    instruction_o = (valid && rst_ni) ? word : '0;
    pc_out_o      = (valid && rst_ni) ? pc_q + STEP : '0;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised + directed bench for if_fetch_unit with a queue-based scoreboard.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;
  logic        req;
  logic [31:0] addr;
  logic        ready = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        stall;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: what the fetch unit is doing, abstractly
  logic [31:0] m_pc = 32'h0;
  bit          m_frozen = 0;     // holding a captured word
  logic [31:0] m_word = '0;
  bit          m_discard = 0;    // redirect pending behind an old request
  logic [31:0] m_target = '0;

  always #5 clk = ~clk;

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .freeze_i(freeze), .branch_taken_i(br),
    .branch_addr_i(br_addr), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ready_i(ready), .imem_rdata_i(rdata), .pc_out_o(pc_out),
    .instruction_o(instr), .fetch_stall_o(stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_req", {31'b0, req}, {31'b0, e.req});
        if (e.req) chk("imem_addr", addr, e.addr);
        chk("instruction", instr, e.instr);
        chk("pc_out", pc_out, e.pc_out);
        chk("fetch_stall", {31'b0, stall}, {31'b0, e.stall});
      end
    end
  end

  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0; ready = 1'b1; rdata = $urandom; freeze = 1'b0; br = 1'b0;
    e = '{req: 1'b0, addr: 32'h0, instr: 32'h0, pc_out: 32'h0, stall: 1'b0};
    exp_q.push_back(e);
    m_pc = 32'h0; m_frozen = 0; m_word = '0; m_discard = 0; m_target = '0;
  endtask

  task automatic step(input bit fz, input bit b, input logic [31:0] ba,
                      input bit rdy, input logic [31:0] rd);
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b1; freeze = fz; br = b; br_addr = ba; ready = rdy; rdata = rd;
    e = '{req: 1'b0, addr: m_pc, instr: 32'h0, pc_out: 32'h0, stall: 1'b0};
    if (m_frozen) begin
      e.instr = m_word; e.pc_out = m_pc + 32'd4;
      if (b) begin m_pc = ba; m_frozen = 0; end
      else if (!fz) begin m_pc = m_pc + 32'd4; m_frozen = 0; end
    end else if (m_discard) begin
      e.req = 1'b1; e.stall = 1'b1;
      if (rdy) begin m_pc = b ? ba : m_target; m_discard = 0; end
      else if (b) m_target = ba;
    end else begin
      e.req = 1'b1;
      if (rdy) begin
        e.instr = rd; e.pc_out = m_pc + 32'd4;
        if (b) m_pc = ba;
        else if (fz) begin m_word = rd; m_frozen = 1; end
        else m_pc = m_pc + 32'd4;
      end else begin
        e.stall = 1'b1;
        if (b) begin m_discard = 1; m_target = ba; end
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    int guard;
    do_reset();
    // zero-wait sequential fetch
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hA000_0000 + i);
    // memory wait at 0x8
    do_reset();
    step(0, 0, 0, 1, 32'h11); step(0, 0, 0, 1, 32'h22);
    step(0, 0, 0, 0, 32'hDEAD); step(0, 0, 0, 0, 32'hBEEF);
    step(0, 0, 0, 1, 32'h33);
    // freeze on a ready fetch at 0x10
    step(0, 0, 0, 1, 32'h44);
    step(1, 0, 0, 1, 32'hE3A01005);
    step(1, 0, 0, 1, 32'h5555); step(1, 0, 0, 1, 32'h6666);
    step(0, 0, 0, 1, 32'h6666);
    step(0, 0, 0, 1, 32'h77);
    // double redirect while waiting at 0x20
    step(0, 1, 32'h20, 1, 32'h88);
    step(0, 1, 32'h100, 0, 32'h0);
    step(0, 1, 32'h200, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'hBAD0_0001);
    step(0, 0, 0, 1, 32'h99);
    // branch and freeze together while holding
    step(1, 0, 0, 1, 32'hAB);
    step(1, 1, 32'h300, 0, 32'h0);
    step(0, 0, 0, 1, 32'hCD);
    // PC wrap at top of address space
    step(0, 1, 32'hFFFF_FFF8, 1, 32'h1);
    step(0, 0, 0, 1, 32'h2); step(0, 0, 0, 1, 32'h3); step(0, 0, 0, 1, 32'h4);
    // reset in the middle of a drain
    step(0, 1, 32'h40, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    do_reset();
    step(0, 0, 0, 1, 32'h5A5A);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0, $urandom);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(negedge clk); #1; guard++; end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
